// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM multicycle controller: FSM state codes,
// datapath select encodings, instruction field codes and the ALU decoder.
package arm_ctrl_pkg;

    // Main FSM state codes
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_EXECR  = 4'd2;
    localparam logic [3:0] S_EXECI  = 4'd3;
    localparam logic [3:0] S_ALUWB  = 4'd4;
    localparam logic [3:0] S_MEMADR = 4'd5;
    localparam logic [3:0] S_MEMRD  = 4'd6;
    localparam logic [3:0] S_MEMWB  = 4'd7;
    localparam logic [3:0] S_MEMWR  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    // ALUControl encodings
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    // ResultSrc encodings
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA encodings
    localparam logic [1:0] SRCA_A      = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // ImmSrc encodings
    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    // Op field codes
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // cmd field codes understood by the ALU decoder
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // ALU decoder result: operation, register write, supported op, arithmetic op
    typedef struct packed {
        logic [1:0] alu_ctl;
        logic       reg_w;
        logic       valid;
        logic       arith;
    } alu_dec_t;

    // Map a data-processing cmd onto the ALU operation and its side effects
    function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
        alu_dec_t d;
        case (cmd)
            CMD_ADD: d = '{alu_ctl: ALU_ADD, reg_w: 1'b1, valid: 1'b1, arith: 1'b1};
            CMD_SUB: d = '{alu_ctl: ALU_SUB, reg_w: 1'b1, valid: 1'b1, arith: 1'b1};
            CMD_AND: d = '{alu_ctl: ALU_AND, reg_w: 1'b1, valid: 1'b1, arith: 1'b0};
            CMD_ORR: d = '{alu_ctl: ALU_ORR, reg_w: 1'b1, valid: 1'b1, arith: 1'b0};
            CMD_CMP: d = '{alu_ctl: ALU_SUB, reg_w: 1'b0, valid: 1'b1, arith: 1'b1};
            default: d = '{alu_ctl: ALU_ADD, reg_w: 1'b0, valid: 1'b0, arith: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arm_mc_controller_cond_unit.sv
// Conditional-execution unit: NZCV flags register, flag-write gating and
// CondEx evaluation of the instruction condition against the stored flags.
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags_i,
    input  logic       flag_req_i,
    input  logic       cv_req_i,
    output logic       cond_ex_o
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex_s;
    logic       n_s, z_s, c_s, v_s;

    assign {n_s, z_s, c_s, v_s} = flags_q;

    // Evaluate the condition field against the stored flags; 1111 never executes
    always_comb begin
        cond_ex_s = 1'b0;
        case (cond_i)
            COND_EQ: cond_ex_s = z_s;
            COND_NE: cond_ex_s = ~z_s;
            COND_CS: cond_ex_s = c_s;
            COND_CC: cond_ex_s = ~c_s;
            COND_MI: cond_ex_s = n_s;
            COND_PL: cond_ex_s = ~n_s;
            COND_VS: cond_ex_s = v_s;
            COND_VC: cond_ex_s = ~v_s;
            COND_HI: cond_ex_s = c_s & ~z_s;
            COND_LS: cond_ex_s = ~c_s | z_s;
            COND_GE: cond_ex_s = (n_s == v_s);
            COND_LT: cond_ex_s = (n_s != v_s);
            COND_GT: cond_ex_s = ~z_s & (n_s == v_s);
            COND_LE: cond_ex_s = z_s | (n_s != v_s);
            COND_AL: cond_ex_s = 1'b1;
            default: cond_ex_s = 1'b0;
        endcase
    end

    // Next flags: NZ always on a granted write, CV only for arithmetic ops
    always_comb begin
        flags_d = flags_q;
        if (flag_req_i && cond_ex_s) begin
            flags_d[3:2] = alu_flags_i[3:2];
            if (cv_req_i) begin
                flags_d[1:0] = alu_flags_i[1:0];
            end else begin
                flags_d[1:0] = flags_q[1:0];
            end
        end else begin
            flags_d = flags_q;
        end
    end

    // NZCV register, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign cond_ex_o = cond_ex_s;

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control unit: Moore main FSM, ALU/flag decoder and
// conditional execution. Optional byte-load support under ARM_MC_LDRB_EN.
module arm_mc_controller
    import arm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        LDRB,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);

    logic [3:0] state_q;
    logic [3:0] state_d;

    logic [1:0] op_s;
    logic       i_s, s_s, l_s, b_s, link_s, rd15_s;
    logic [3:0] cmd_s;
    alu_dec_t   dec_s;
    logic       cond_ex_s;
    logic       flag_req_s;
    logic       unused_instr_s;

    logic       pc_write_s, reg_write_s, mem_write_s, ir_write_s, ldrb_s;

    assign op_s    = Instr[27:26];
    assign i_s     = Instr[25];
    assign cmd_s   = Instr[24:21];
    assign s_s     = Instr[20];
    assign l_s     = Instr[20];
    assign b_s     = Instr[22];
    assign link_s  = Instr[24];
    assign rd15_s  = (Instr[15:12] == 4'hF);
    assign dec_s   = alu_decode(cmd_s);
    assign unused_instr_s = ^{Instr[23], Instr[19:16], Instr[11:0]};

    // Flags are written at the end of an execute cycle for S-form or CMP ops
    assign flag_req_s = ((state_q == S_EXECR) || (state_q == S_EXECI)) &&
                        (s_s || (cmd_s == CMD_CMP)) && dec_s.valid;

    cond_unit u_cond_unit (
        .clk         (clk),
        .rst_n       (reset),
        .cond_i      (Instr[31:28]),
        .alu_flags_i (ALUFlags),
        .flag_req_i  (flag_req_s),
        .cv_req_i    (dec_s.arith),
        .cond_ex_o   (cond_ex_s)
    );

    // Next-state selection for the main FSM
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op_s)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = i_s ? S_EXECI : S_EXECR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            S_MEMADR: state_d = l_s ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register; reset returns immediately to FETCH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore outputs per state, with conditional enables gated by CondEx
    always_comb begin
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        ldrb_s      = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = SRCA_A;
        ALUSrcB     = SRCB_REG;
        ResultSrc   = RES_ALUOUT;
        ALUControl  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_EXECR: begin
                ALUControl = dec_s.alu_ctl;
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_s.alu_ctl;
            end
            S_ALUWB: begin
                reg_write_s = dec_s.reg_w & cond_ex_s;
                pc_write_s  = dec_s.reg_w & cond_ex_s & rd15_s;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
`ifdef ARM_MC_LDRB_EN
                ldrb_s = b_s;
`else
                ldrb_s = 1'b0;
`endif
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                reg_write_s = cond_ex_s;
                pc_write_s  = cond_ex_s & rd15_s;
`ifdef ARM_MC_LDRB_EN
                ldrb_s = b_s;
`else
                ldrb_s = 1'b0;
`endif
            end
            S_MEMWR: begin
                AdrSrc      = 1'b1;
                mem_write_s = cond_ex_s;
            end
            S_BRANCH: begin
                ALUSrcA     = SRCA_ALUOUT;
                ALUSrcB     = SRCB_IMM;
                ResultSrc   = RES_ALURESULT;
                pc_write_s  = cond_ex_s;
                reg_write_s = link_s & cond_ex_s;
            end
            default: begin
                ir_write_s = 1'b0;
            end
        endcase
    end

`ifndef ARM_MC_LDRB_EN
    logic unused_b_s;
    assign unused_b_s = b_s;
`endif

    // Instruction-format decode, valid in every state
    assign ImmSrc    = op_s;
    assign RegSrc[0] = (op_s == OP_BR);
    assign RegSrc[1] = (op_s == OP_MEM) && !l_s;

    // Enables held low for as long as reset is asserted
    assign PCWrite  = pc_write_s  & reset;
    assign RegWrite = reg_write_s & reset;
    assign MemWrite = mem_write_s & reset;
    assign IRWrite  = ir_write_s  & reset;
    assign LDRB     = ldrb_s      & reset;

endmodule
